// File: rtl/ysyx_25010008_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_25010008_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

    // Request fields held stable towards the slave for the whole transaction
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '0;

    // Map a one-hot grant (bit 0 = IFU, bit 1 = LSU) onto the owner encoding
    function automatic owner_t grant_owner(input logic [1:0] grant);
        return grant[1] ? OWNER_LSU : OWNER_IFU;
    endfunction

endpackage

// File: rtl/ysyx_25010008_mem_arbiter_if.sv
// Bundle of every IFU, LSU and memory-side signal around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on requests; responses are single-cycle pulses with no ready.
interface ysyx_25010008_mem_arbiter_if;
    import ysyx_25010008_mem_arbiter_pkg::*;

    // IFU side (read-only master)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_rdata;
    logic              ifu_resp_err;

    // LSU side (read/write master)
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_req_wen;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_rdata;
    logic              lsu_resp_err;

    // Memory slave side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    // Arbiter view: it serves the two masters and drives the memory port
    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    // Surroundings view: IFU, LSU and the memory model together
    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

endinterface

// File: rtl/ysyx_25010008_mem_arbiter_rr_pick.sv
// Two-way round-robin picker: one-hot grant from a valid pair and the previous winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is actually taken.
module ysyx_25010008_rr_pick
    import ysyx_25010008_mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,   // bit 0 = IFU, bit 1 = LSU
    input  owner_t     last,
    output logic [1:0] grant
);

    // A lone requester always wins; a tie goes to whoever did not win last time
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == OWNER_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_25010008_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time, round-robin on ties.
// Latency: grant in cycle 0, mem request from cycle 1, response passed through in the slave's response cycle.
// Backpressure: req_ready only in IDLE; mem_req held until mem_req_ready; slave stalls in WAIT end in an error after TIMEOUT.
module ysyx_25010008_mem_arbiter
    import ysyx_25010008_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,   // legal range 1 .. 2**CW-1
    parameter int CW      = 8
) (
    input  logic                         clk,
    input  logic                         rst,   // asynchronous, active low
    ysyx_25010008_mem_arbiter_if.slave   bus
);

    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    state_t        state;
    state_t        next_state;
    owner_t        owner;
    owner_t        last_grant;
    logic [CW-1:0] cnt;
    mem_req_t      req_q;
    mem_req_t      req_new;

    logic [1:0]    pick;
    logic [1:0]    grant;
    logic          resp_hit;
    logic          timeout_hit;
    logic          done;
    logic [DATA_W-1:0] resp_rdata;
    logic          resp_err;
    logic          ifu_done;
    logic          lsu_done;

    ysyx_25010008_rr_pick u_pick (
        .valid ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .last  (last_grant),
        .grant (pick)
    );

    // The picker's choice only becomes a grant while the port is free
    assign grant = (state == ST_IDLE) ? pick : 2'b00;

    // Capture the winning master's fields; IFU traffic is always a plain read
    always_comb begin
        req_new = REQ_NONE;
        if (grant[1]) begin
            req_new.wen   = bus.lsu_req_wen;
            req_new.addr  = bus.lsu_req_addr;
            req_new.wdata = bus.lsu_req_wdata;
            req_new.wmask = bus.lsu_req_wmask;
        end else begin
            req_new.addr  = bus.ifu_req_addr;
        end
    end

    // Next state; a real response in WAIT beats a timeout in the same cycle
    always_comb begin
        next_state  = state;
        resp_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_hit   = 1'b1;
                    next_state = ST_IDLE;
                end else if (cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register; reset drops whatever transaction is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Owner and round-robin history move together on every grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWNER_IFU;
            last_grant <= OWNER_LSU;
        end else if (|grant) begin
            owner      <= grant_owner(grant);
            last_grant <= grant_owner(grant);
        end
    end

    // Request fields are frozen at grant time so the master may change its inputs afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= REQ_NONE;
        end else if (|grant) begin
            req_q <= req_new;
        end
    end

    // WAIT cycle counter: cleared on the slave handshake, saturates at TIMEOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ST_REQ && bus.mem_req_ready) begin
            cnt <= '0;
        end else if (state == ST_WAIT && !bus.mem_resp_valid && cnt != TIMEOUT_CNT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Response data: writes never return read data, timeouts return zero with err set
    assign done       = resp_hit | timeout_hit;
    assign resp_rdata = (resp_hit && !req_q.wen) ? bus.mem_resp_rdata : '0;
    assign resp_err   = resp_hit ? bus.mem_resp_err : timeout_hit;
    assign ifu_done   = done && (owner == OWNER_IFU);
    assign lsu_done   = done && (owner == OWNER_LSU);

    // Ready is forced low during reset because IDLE would otherwise grant combinationally
    assign bus.ifu_req_ready  = rst & grant[0];
    assign bus.lsu_req_ready  = rst & grant[1];

    assign bus.ifu_resp_valid = ifu_done;
    assign bus.ifu_resp_rdata = ifu_done ? resp_rdata : '0;
    assign bus.ifu_resp_err   = ifu_done & resp_err;
    assign bus.lsu_resp_valid = lsu_done;
    assign bus.lsu_resp_rdata = lsu_done ? resp_rdata : '0;
    assign bus.lsu_resp_err   = lsu_done & resp_err;

    assign bus.mem_req_valid  = (state == ST_REQ);
    assign bus.mem_req_wen    = req_q.wen;
    assign bus.mem_req_addr   = req_q.addr;
    assign bus.mem_req_wdata  = req_q.wdata;
    assign bus.mem_req_wmask  = req_q.wmask;

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT=4.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: the memory model controls mem_req_ready and response timing per vector.
module tb_ysyx_25010008_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ifu_left;
    int   lsu_left;

    ysyx_25010008_mem_arbiter_if bus();

    ysyx_25010008_mem_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full round trip with the caller's request lines already set: grant, one-cycle REQ, immediate response
    task automatic serve(input string tag, input bit exp_lsu, input logic [31:0] data, input bit err);
        #1;
        chk({tag, "_ifu_rdy"}, 32'(bus.ifu_req_ready), 32'(!exp_lsu));
        chk({tag, "_lsu_rdy"}, 32'(bus.lsu_req_ready), 32'(exp_lsu));
        tick();
        bus.mem_req_ready = 1'b1;
        #1;
        chk({tag, "_mem_vld"}, 32'(bus.mem_req_valid), 32'd1);
        chk({tag, "_busy_rdy"}, 32'(bus.ifu_req_ready | bus.lsu_req_ready), 32'd0);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = data;
        bus.mem_resp_err   = err;
        #1;
        chk({tag, "_ifu_rsp"}, 32'(bus.ifu_resp_valid), 32'(!exp_lsu));
        chk({tag, "_lsu_rsp"}, 32'(bus.lsu_resp_valid), 32'(exp_lsu));
        chk({tag, "_rdata"}, exp_lsu ? bus.lsu_resp_rdata : bus.ifu_resp_rdata, data);
        chk({tag, "_err"}, 32'(exp_lsu ? bus.lsu_resp_err : bus.ifu_resp_err), 32'(err));
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        bus.mem_resp_err   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_req_addr   = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_wen    = 1'b0;
        bus.lsu_req_addr   = '0;
        bus.lsu_req_wdata  = '0;
        bus.lsu_req_wmask  = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        bus.mem_resp_err   = 1'b0;
        tick();
        tick();

        // Reset: everything low even with requests and a slave response present
        bus.ifu_req_valid  = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        #1;
        chk("rst_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        chk("rst_lsu_rdy", 32'(bus.lsu_req_ready), 32'd0);
        chk("rst_mem_vld", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_req_addr, 32'd0);
        chk("rst_ifu_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        chk("rst_lsu_rsp", 32'(bus.lsu_resp_valid), 32'd0);
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Single IFU read: slave ready in cycle 1, data in cycle 3
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0000;
        #1;
        chk("t1_ifu_rdy", 32'(bus.ifu_req_ready), 32'd1);
        chk("t1_lsu_rdy", 32'(bus.lsu_req_ready), 32'd0);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = 32'h0;
        #1;
        chk("t1_mem_vld", 32'(bus.mem_req_valid), 32'd1);
        chk("t1_mem_addr", bus.mem_req_addr, 32'h8000_0000);
        chk("t1_mem_wen", 32'(bus.mem_req_wen), 32'd0);
        chk("t1_mem_wmask", 32'(bus.mem_req_wmask), 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        chk("t1_c2_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        chk("t1_c2_mem_vld", 32'(bus.mem_req_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h0000_0413;
        #1;
        chk("t1_rsp", 32'(bus.ifu_resp_valid), 32'd1);
        chk("t1_rdata", bus.ifu_resp_rdata, 32'h0000_0413);
        chk("t1_err", 32'(bus.ifu_resp_err), 32'd0);
        chk("t1_lsu_rsp", 32'(bus.lsu_resp_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // LSU write: latched fields survive the master changing its inputs
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_addr  = 32'h8000_1000;
        bus.lsu_req_wdata = 32'hDEAD_BEEF;
        bus.lsu_req_wmask = 4'h3;
        #1;
        chk("t2_lsu_rdy", 32'(bus.lsu_req_ready), 32'd1);
        chk("t2_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_addr  = 32'h1234_5678;
        bus.lsu_req_wdata = 32'h0;
        bus.lsu_req_wmask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("t2_vld%0d", i), 32'(bus.mem_req_valid), 32'd1);
            chk($sformatf("t2_wen%0d", i), 32'(bus.mem_req_wen), 32'd1);
            chk($sformatf("t2_addr%0d", i), bus.mem_req_addr, 32'h8000_1000);
            chk($sformatf("t2_wdata%0d", i), bus.mem_req_wdata, 32'hDEAD_BEEF);
            chk($sformatf("t2_wmask%0d", i), 32'(bus.mem_req_wmask), 32'h3);
            bus.mem_req_ready = (i == 1);
            tick();
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hCAFE_F00D;
        #1;
        chk("t2_rsp", 32'(bus.lsu_resp_valid), 32'd1);
        chk("t2_rdata", bus.lsu_resp_rdata, 32'd0);
        chk("t2_ifu_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // Both masters hold valid for three transactions each: strict alternation starting with IFU
        ifu_left = 3;
        lsu_left = 3;
        bus.ifu_req_addr = 32'h8000_0040;
        bus.lsu_req_addr = 32'h8000_0080;
        for (int i = 0; i < 6; i++) begin
            bus.ifu_req_valid = (ifu_left > 0);
            bus.lsu_req_valid = (lsu_left > 0);
            serve($sformatf("rr%0d", i), (i % 2) == 1, 32'h1000 + 32'(i), i == 3);
            if ((i % 2) == 0) ifu_left--;
            else lsu_left--;
        end
        bus.ifu_req_valid = 1'b0;

        // A lone master is granted back-to-back even though it won last time
        bus.lsu_req_valid = 1'b1;
        serve("b2b0", 1'b1, 32'h2000, 1'b0);
        serve("b2b1", 1'b1, 32'h2001, 1'b0);
        bus.lsu_req_valid = 1'b0;

        // Slave accepts but never answers: error pulse after four quiet WAIT cycles
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0100;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_quiet%0d", i), 32'(bus.ifu_resp_valid), 32'd0);
            tick();
        end
        #1;
        chk("to_rsp", 32'(bus.ifu_resp_valid), 32'd1);
        chk("to_err", 32'(bus.ifu_resp_err), 32'd1);
        chk("to_rdata", bus.ifu_resp_rdata, 32'd0);
        chk("to_lsu_rsp", 32'(bus.lsu_resp_valid), 32'd0);
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h1111_1111;
        #1;
        chk("late_ifu_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        chk("late_lsu_rsp", 32'(bus.lsu_resp_valid), 32'd0);
        chk("late_ifu_rdata", bus.ifu_resp_rdata, 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // Response in the very cycle the timeout would fire carries real data, no error
        bus.ifu_req_valid = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h0000_0055;
        #1;
        chk("tie_rsp", 32'(bus.ifu_resp_valid), 32'd1);
        chk("tie_err", 32'(bus.ifu_resp_err), 32'd0);
        chk("tie_rdata", bus.ifu_resp_rdata, 32'h0000_0055);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // Slave stalls 20 cycles in REQ while the master changes its address: no timeout
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_addr  = 32'h8000_2000;
        #1;
        chk("st_lsu_rdy", 32'(bus.lsu_req_ready), 32'd1);
        tick();
        bus.lsu_req_addr = 32'h9999_0000;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("st_addr%0d", i), bus.mem_req_addr, 32'h8000_2000);
            chk($sformatf("st_vld%0d", i), 32'(bus.mem_req_valid), 32'd1);
            chk($sformatf("st_rsp%0d", i), 32'(bus.lsu_resp_valid), 32'd0);
            tick();
        end
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h0000_0077;
        #1;
        chk("st_rsp", 32'(bus.lsu_resp_valid), 32'd1);
        chk("st_rdata", bus.lsu_resp_rdata, 32'h0000_0077);
        chk("st_err", 32'(bus.lsu_resp_err), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // Reset asserted during WAIT: outputs clear at once, stale response ignored afterwards
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0200;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        rst               = 1'b0;
        bus.ifu_req_valid = 1'b1;
        #1;
        chk("rw_mem_vld", 32'(bus.mem_req_valid), 32'd0);
        chk("rw_mem_addr", bus.mem_req_addr, 32'd0);
        chk("rw_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        chk("rw_ifu_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        chk("rw_lsu_rsp", 32'(bus.lsu_resp_valid), 32'd0);
        tick();
        rst                = 1'b1;
        bus.ifu_req_addr   = 32'h8000_0300;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hDEAD_0000;
        #1;
        chk("rw_stale_rsp", 32'(bus.ifu_resp_valid), 32'd0);
        chk("rw_regrant", 32'(bus.ifu_req_ready), 32'd1);
        tick();
        bus.ifu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        #1;
        chk("rw_mem_vld2", 32'(bus.mem_req_valid), 32'd1);
        chk("rw_mem_addr2", bus.mem_req_addr, 32'h8000_0300);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h0000_0099;
        #1;
        chk("rw_rsp", 32'(bus.ifu_resp_valid), 32'd1);
        chk("rw_rdata", bus.ifu_resp_rdata, 32'h0000_0099);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25010008_mem_arbiter.md
# ysyx_25010008_mem_arbiter

Two-master, one-slave memory arbiter. It shares the single memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It holds one transaction outstanding at a time, picks round-robin on simultaneous requests, and returns an error response to the requester if the slave stalls past a timeout. It sits between IFU/LSU and the memory slave inside the NPC top level.

## Interface
- TIMEOUT, 255: maximum cycles in WAIT before a forced error response; legal range 1..2^CW-1.
- CW, 8: timeout counter width.

- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  32  IFU read address.
- ifu_resp_valid  out  1  one-cycle IFU response pulse.
- ifu_resp_rdata  out  32  IFU read data.
- ifu_resp_err  out  1  IFU bus or timeout error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_addr  in  32  LSU address.
- lsu_req_wdata  in  32  LSU write data.
- lsu_req_wmask  in  4  LSU byte-write mask.
- lsu_resp_valid  out  1  one-cycle LSU response pulse.
- lsu_resp_rdata  out  32  LSU read data; 0 for writes.
- lsu_resp_err  out  1  LSU bus or timeout error.
- mem_req_valid  out  1  request to slave.
- mem_req_ready  in  1  slave accepts request.
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/32/32/4  latched request fields.
- mem_resp_valid  in  1  slave response; the arbiter always accepts it.
- mem_resp_rdata  in  32  slave read data.
- mem_resp_err  in  1  slave error.

## Operation
- States: IDLE, REQ, WAIT. The owner register records IFU or LSU. The last-grant register resets to LSU.
- IDLE:
  - If exactly one master has req_valid, grant it.
  - If both are valid, grant the master that was not granted last.
  - The granted master's req_ready is driven high combinationally in the same cycle.
  - The arbiter latches addr, wen, wdata and wmask. For IFU, wen=0 and wmask=0.
  - It updates the owner and last-grant registers and moves to REQ.
- REQ:
  - mem_req_valid=1 with the latched fields; the fields stay stable until the handshake.
  - On mem_req_ready, move to WAIT and clear the counter.
- WAIT:
  - When mem_resp_valid is seen, route rdata and err to the owner's resp_* for that same cycle (combinational pass-through) and return to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, pulse the owner's resp_valid with err=1 and rdata=0, then return to IDLE.
- Any mem_resp_valid arriving in IDLE or REQ (for example, a late response after a timeout) is discarded.
- Both req_ready outputs are 0 outside IDLE. A new grant is therefore possible only one cycle after a response.
- The non-owner's resp_valid is always 0. resp_rdata and resp_err are 0 whenever resp_valid is 0.
- Reset, asynchronous, also mid-transaction:
  - state = IDLE, owner = IFU, last-grant = LSU, counter = 0, latched fields = 0.
  - All outputs are 0 while rst is low, including req_ready.
  - Any in-flight transaction is dropped.

## Timing
- Minimum round trip: request in cycle 0, mem_req_valid in cycle 1. With the slave ready in cycle 1 and responding in cycle 2, the master sees resp_valid in cycle 2 and can be re-granted in cycle 3.
- In REQ, mem_req_valid is held with no timeout; the timeout applies only in WAIT.
- The counter saturates at TIMEOUT. A response arriving in the same cycle the timeout fires wins: real data, err = mem_resp_err.
- Simultaneous requests in consecutive transactions alternate IFU/LSU. A master that keeps req_valid high with no competitor is granted back-to-back.

## Structure
- Shared package: state encoding (IDLE/REQ/WAIT), owner encoding (OWNER_IFU=0, OWNER_LSU=1), the 32-bit address/data width constants, and a request struct (wen, addr, wdata, wmask).
- One natural sub-module: ysyx_25010008_rr_pick, a 2-way round-robin picker (valid pair plus last-grant in, one-hot grant out). Everything else stays flat.

## Test plan
- Single IFU read, addr 0x8000_0000; slave ready in cycle 1, data 0x0000_0413 in cycle 3 -> ifu_resp_valid pulses in cycle 3 with rdata 0x0000_0413 and err=0; lsu_resp_valid stays 0.
- LSU write, addr 0x8000_1000, wdata 0xDEADBEEF, wmask 0x3 -> mem_req_* carries exactly these values until mem_req_ready; lsu_resp_valid pulses with rdata 0.
- Both masters valid out of reset, each holding valid for 3 transactions -> grant order IFU, LSU, IFU, LSU, IFU, LSU.
- Slave accepts but never responds, TIMEOUT=4 -> owner resp_valid with err=1 and rdata=0 after 4 WAIT cycles. A slave response 2 cycles later is ignored and produces no resp pulse.
- Slave holds mem_req_ready low for 20 cycles while the master changes its addr -> mem_req_addr stays at the originally accepted value and no timeout fires.
- rst driven low during WAIT -> all outputs are 0 immediately. After release, the next IFU request is granted from IDLE and the stale slave response is discarded.
